// File: rtl/bounce_pkg.sv
// bounce_pkg: raster timing constants, motion FSM state type and the per-axis step helper
package bounce_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP = 33;
    localparam int SQ_SIZE = 32;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
    localparam int X_MAX = H_ACTIVE - SQ_SIZE;
    localparam int Y_MAX = V_ACTIVE - SQ_SIZE;

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} motion_state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       neg;
        logic       bounce;
    } step_t;

    function automatic step_t axis_step(logic [9:0] pos, logic neg, logic [2:0] s, logic [9:0] lim);
        step_t r;
        logic [10:0] sum;
        sum = {1'b0, pos} + {8'd0, s};
        r.pos = pos;
        r.neg = neg;
        r.bounce = 1'b0;
        if (s != 3'd0) begin
            if (!neg) begin
                r.pos = (sum >= {1'b0, lim}) ? lim : sum[9:0];
                r.neg = sum >= {1'b0, lim};
                r.bounce = sum >= {1'b0, lim};
            end else begin
                r.pos = (pos <= {7'd0, s}) ? 10'd0 : pos - {7'd0, s};
                r.neg = !(pos <= {7'd0, s});
                r.bounce = pos <= {7'd0, s};
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bounce_motion_ctrl_if.sv
// bounce_motion_ctrl_if: motion inputs and raster/square outputs between the controller and the pin mux
interface bounce_motion_ctrl_if;
    logic       pause;
    logic [2:0] speed;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [9:0] sq_x;
    logic [9:0] sq_y;
    logic       pixel_on;
    logic       upd_pulse;
    logic       bounce_x;
    logic       bounce_y;
    logic [2:0] color;

    modport master (
        input  pause, speed,
        output hsync, vsync, active, hpos, vpos, sq_x, sq_y, pixel_on, upd_pulse, bounce_x, bounce_y, color
    );

    modport slave (
        output pause, speed,
        input  hsync, vsync, active, hpos, vpos, sq_x, sq_y, pixel_on, upd_pulse, bounce_x, bounce_y, color
    );
endinterface

// File: rtl/vga_raster_cnt.sv
// vga_raster_cnt: horizontal/vertical raster counters with active-low sync and visible-region decode
module vga_raster_cnt #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       active
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos <= '0;
            vpos <= '0;
        end else begin
            hpos <= (hpos == H_LAST) ? '0 : hpos + 10'd1;
            if (hpos == H_LAST) vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
        end
    end

    assign hsync = !(hpos >= HS_START && hpos < HS_END);
    assign vsync = !(vpos >= VS_START && vpos < VS_END);
    assign active = hpos < 10'(H_ACTIVE) && vpos < 10'(V_ACTIVE);
endmodule

// File: rtl/bounce_motion_ctrl.sv
// bounce_motion_ctrl: raster timing plus a once-per-frame square step in vblank; BOUNCE_COLOR_EN adds a bounce-stepped colour register
module bounce_motion_ctrl
    import bounce_pkg::*;
#(
    parameter int H_ACTIVE = bounce_pkg::H_ACTIVE,
    parameter int H_FP = bounce_pkg::H_FP,
    parameter int H_SYNC = bounce_pkg::H_SYNC,
    parameter int H_BP = bounce_pkg::H_BP,
    parameter int V_ACTIVE = bounce_pkg::V_ACTIVE,
    parameter int V_FP = bounce_pkg::V_FP,
    parameter int V_SYNC = bounce_pkg::V_SYNC,
    parameter int V_BP = bounce_pkg::V_BP,
    parameter int SQ_SIZE = bounce_pkg::SQ_SIZE
) (
    input logic clk,
    input logic rst,
    bounce_motion_ctrl_if.master bus
);
    localparam logic [9:0] X_LIM = 10'(H_ACTIVE - SQ_SIZE);
    localparam logic [9:0] Y_LIM = 10'(V_ACTIVE - SQ_SIZE);
    localparam logic [9:0] SQ = 10'(SQ_SIZE);
    localparam logic [9:0] TRIG_LINE = 10'(V_ACTIVE);

    motion_state_t state, state_nx;
    logic [9:0] hpos, vpos, sq_x, sq_y;
    logic active, trig, upd, dir_x_neg, dir_y_neg, bounce_x, bounce_y;
    logic [2:0] spd;
    step_t step_x, step_y;

    vga_raster_cnt #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_raster (
        .clk(clk),
        .rst(rst),
        .hpos(hpos),
        .vpos(vpos),
        .hsync(bus.hsync),
        .vsync(bus.vsync),
        .active(active)
    );

    always_comb begin
        trig = hpos == '0 && vpos == TRIG_LINE;
        upd = state == DONE;
        step_x = axis_step(sq_x, dir_x_neg, spd, X_LIM);
        step_y = axis_step(sq_y, dir_y_neg, spd, Y_LIM);
        state_nx = state == IDLE ? ((trig && !bus.pause) ? MOVE_X : IDLE) :
                   state == MOVE_X ? MOVE_Y :
                   state == MOVE_Y ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sq_x <= '0;
            sq_y <= '0;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            spd <= '0;
        end else begin
            state <= state_nx;
            bounce_x <= state == MOVE_X && step_x.bounce;
            bounce_y <= state == MOVE_Y && step_y.bounce;
            if (state == IDLE && trig) spd <= bus.speed;
            if (state == MOVE_X) begin
                sq_x <= step_x.pos;
                dir_x_neg <= step_x.neg;
            end
            if (state == MOVE_Y) begin
                sq_y <= step_y.pos;
                dir_y_neg <= step_y.neg;
            end
        end
    end

`ifdef BOUNCE_COLOR_EN
    logic [2:0] color;
    logic bounced;
    // a two-axis bounce still counts once: the flag just ORs both axes over the sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            color <= '0;
            bounced <= 1'b0;
        end else begin
            bounced <= state == IDLE ? 1'b0 :
                       bounced | (state == MOVE_X && step_x.bounce) | (state == MOVE_Y && step_y.bounce);
            if (state == DONE && bounced) color <= color + 3'd1;
        end
    end
    assign bus.color = color;
`else
    assign bus.color = 3'd7;
`endif

    assign bus.hpos = hpos;
    assign bus.vpos = vpos;
    assign bus.active = active;
    assign bus.sq_x = sq_x;
    assign bus.sq_y = sq_y;
    assign bus.upd_pulse = upd;
    assign bus.bounce_x = bounce_x;
    assign bus.bounce_y = bounce_y;
    assign bus.pixel_on = active && hpos >= sq_x && hpos < sq_x + SQ && vpos >= sq_y && vpos < sq_y + SQ;
endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// tb_bounce_motion_ctrl: table, corner-sequence and random checks of bounce_motion_ctrl on a reduced raster
module tb_bounce_motion_ctrl;
    localparam int HA = 24, HF = 4, HS = 8, HB = 4;
    localparam int VA = 20, VF = 2, VS = 2, VB = 6, SQ = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int TRIG = VA * HT;
    localparam int XM = HA - SQ;
    localparam int YM = VA - SQ;

    typedef struct {
        bit pause;
        int speed;
        int x;
        int y;
        bit bx;
        bit by;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bounce_motion_ctrl_if bus();

    int c, mx, my, ls, mcol, npass, ntot;
    bit dxn, dyn, go, mb, ebx, eby, eupd;
    vec_t tv [12];

    bounce_motion_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SQ_SIZE(SQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, c, act, exp);
    endtask

    task automatic check_vec(input logic [49:0] act, input logic [49:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL outputs at cycle %0d: got %h expected %h", c, act, exp);
    endtask

    task automatic move(inout int pos, inout bit neg, input int s, input int lim, output bit b);
        b = 1'b0;
        if (s == 0) return;
        if (!neg) begin
            if (pos + s >= lim) begin pos = lim; neg = 1'b1; b = 1'b1; end
            else pos = pos + s;
        end else begin
            if (pos <= s) begin pos = 0; neg = 1'b0; b = 1'b1; end
            else pos = pos - s;
        end
    endtask

    function automatic logic [49:0] expected();
        int h, v, col;
        bit act, pix;
        h = c % HT;
        v = (c / HT) % VT;
        act = h < HA && v < VA;
        pix = act && h >= mx && h < mx + SQ && v >= my && v < my + SQ;
`ifdef BOUNCE_COLOR_EN
        col = mcol;
`else
        col = 7;
`endif
        return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS), act, pix,
                eupd, ebx, eby, 3'(col), 10'(h), 10'(v), 10'(mx), 10'(my)};
    endfunction

    task automatic tick();
        bit r;
        int f;
        r = rst;
        if (!r && c % FRAME == TRIG) begin
            ls = int'(bus.speed);
            go = !bus.pause;
            mb = 1'b0;
        end
        @(posedge clk);
        #1;
        ebx = 1'b0;
        eby = 1'b0;
        eupd = 1'b0;
        if (r) begin
            c = 0; mx = 0; my = 0; dxn = 1'b0; dyn = 1'b0; go = 1'b0; mb = 1'b0; mcol = 0;
        end else begin
            c++;
            f = c % FRAME;
            if (go && f == TRIG + 2) begin move(mx, dxn, ls, XM, ebx); mb = mb | ebx; end
            if (go && f == TRIG + 3) begin move(my, dyn, ls, YM, eby); mb = mb | eby; eupd = 1'b1; end
            if (go && f == TRIG + 4) begin mcol = mb ? (mcol + 1) % 8 : mcol; go = 1'b0; end
        end
        check_vec({bus.hsync, bus.vsync, bus.active, bus.pixel_on, bus.upd_pulse, bus.bounce_x, bus.bounce_y,
                   bus.color, bus.hpos, bus.vpos, bus.sq_x, bus.sq_y}, expected());
    endtask

    task automatic run_to(input int f);
        for (int k = 0; k < FRAME && c % FRAME != f; k++) tick();
        check("reach frame offset", c % FRAME, f);
    endtask

    initial begin
        int lo, first, n, bxs;
        bus.pause = 1'b0;
        bus.speed = 3'd4;
        tv = '{'{0, 4, 4, 4, 0, 0}, '{0, 7, 11, 11, 0, 0}, '{1, 7, 11, 11, 0, 0}, '{0, 0, 11, 11, 0, 0},
               '{0, 7, 18, 16, 0, 1}, '{0, 4, 20, 12, 1, 0}, '{0, 4, 16, 8, 0, 0}, '{0, 6, 10, 2, 0, 0},
               '{0, 7, 3, 0, 0, 1}, '{0, 1, 2, 1, 0, 0}, '{0, 7, 0, 8, 1, 0}, '{0, 3, 3, 11, 0, 0}};

        repeat (3) tick();
        rst = 1'b0;
        check("reset hpos", int'(bus.hpos), 0);
        check("reset vpos", int'(bus.vpos), 0);
        check("reset hsync", int'(bus.hsync), 1);
        check("reset vsync", int'(bus.vsync), 1);
        check("reset active", int'(bus.active), 1);
        check("reset sq_x", int'(bus.sq_x), 0);
        check("reset sq_y", int'(bus.sq_y), 0);
        check("reset upd_pulse", int'(bus.upd_pulse), 0);
`ifdef BOUNCE_COLOR_EN
        check("reset color", int'(bus.color), 0);
`else
        check("reset color", int'(bus.color), 7);
`endif

        lo = 0;
        first = -1;
        for (int k = 0; k < HT; k++) begin
            tick();
            if (!bus.hsync) begin
                lo++;
                if (first < 0) first = int'(bus.hpos);
            end
        end
        check("hsync low cycles", lo, HS);
        check("hsync start hpos", first, HA + HF);

        foreach (tv[i]) begin
            run_to(TRIG - 3);
            bus.pause = tv[i].pause;
            bus.speed = 3'(tv[i].speed);
            run_to(TRIG + 1);
            bus.pause = 1'($urandom);
            bus.speed = 3'($urandom);
            tick();
            check("table sq_x", int'(bus.sq_x), tv[i].x);
            check("table bounce_x", int'(bus.bounce_x), int'(tv[i].bx));
            tick();
            check("table sq_y", int'(bus.sq_y), tv[i].y);
            check("table bounce_y", int'(bus.bounce_y), int'(tv[i].by));
            check("table upd_pulse", int'(bus.upd_pulse), int'(!tv[i].pause));
        end

        run_to(TRIG - 3);
        bus.pause = 1'b0;
        bus.speed = 3'd7;
        run_to(TRIG + 2);
        check("pre-reset sq_x", int'(bus.sq_x), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst sq_x", int'(bus.sq_x), 0);
        check("midrst sq_y", int'(bus.sq_y), 0);
        check("midrst upd_pulse", int'(bus.upd_pulse), 0);
        check("midrst bounce_y", int'(bus.bounce_y), 0);
        check("midrst hpos", int'(bus.hpos), 0);
        check("midrst vpos", int'(bus.vpos), 0);

        run_to(TRIG + 3);
        tick();
        run_to(TRIG + 3);
        n = 0;
        bxs = 0;
        do begin
            tick();
            n++;
            if (bus.bounce_x) bxs++;
        end while (!bus.upd_pulse && n < 2 * FRAME);
        check("frame period", n, FRAME);
        check("dual bounce_x count", bxs, 1);
        check("dual bounce_y", int'(bus.bounce_y), 1);
        check("dual sq_x", int'(bus.sq_x), XM);
        check("dual sq_y", int'(bus.sq_y), YM);
        tick();
`ifdef BOUNCE_COLOR_EN
        check("color after bounce", int'(bus.color), 1);
`else
        check("color tied", int'(bus.color), 7);
`endif

        run_to(0);
        lo = 0;
        first = -1;
        for (int k = 0; k < 15 * FRAME; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                bus.pause = ($urandom_range(0, 3) == 0);
                bus.speed = 3'($urandom);
            end
            tick();
            if (k < FRAME && !bus.vsync) begin
                lo++;
                if (first < 0) first = int'(bus.vpos);
            end
        end
        check("vsync low cycles", lo, VS * HT);
        check("vsync start vpos", first, VA + VF);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
